// File: rtl/spi_register_slave.sv
// SPI responder with a byte-wide register file: 16-bit frames {rw, addr[6:0], data[7:0]}, MSB first.
// Pin edge to action is 3 clocks; no backpressure, the master owns the link timing.
module spi_register_slave #(
   parameter int NUM_REGS = 16
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_sen,
   input  logic       i_sck,
   input  logic       i_sdat,
   output logic       o_sout,
   output logic       o_wrStrobe,
   output logic [6:0] o_wrAddress,
   output logic [7:0] o_wrData,
   output logic       o_rdStrobe,
   output logic       o_frameError
);

   localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t      state, state_nxt;
   logic [2:0]  sen_sync, sck_sync;
   logic [1:0]  sdat_sync;
   logic        sen_rise, sen_fall, sck_rise, sck_fall, sdat_s;
   logic [3:0]  bit_cnt;
   logic [14:0] shreg;
   logic [6:0]  tx;
   logic        rd_active;
   logic [7:0]  regs [NUM_REGS];
   logic        sck_take, load_rd, commit, abort, tx_shift;
   logic [6:0]  rd_addr, wr_addr;
   logic [7:0]  wr_data, rd_val;

   // Bits [1:0] synchronise, bit [2] is the previous value for edge detection.
   // Clearing them to 0 on reset means a frame cut by reset restarts only after sen goes high then low.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         sen_sync  <= '0;
         sck_sync  <= '0;
         sdat_sync <= '0;
      end else begin
         sen_sync  <= {sen_sync[1:0], i_sen};
         sck_sync  <= {sck_sync[1:0], i_sck};
         sdat_sync <= {sdat_sync[0], i_sdat};
      end
   end

   assign sen_rise = sen_sync[1] & ~sen_sync[2];
   assign sen_fall = ~sen_sync[1] & sen_sync[2];
   assign sck_rise = sck_sync[1] & ~sck_sync[2];
   assign sck_fall = ~sck_sync[1] & sck_sync[2];
   assign sdat_s   = sdat_sync[1];

   // Fields are taken with the bit arriving this cycle appended to the shift register.
   assign rd_addr = {shreg[5:0], sdat_s};
   assign wr_addr = shreg[13:7];
   assign wr_data = {shreg[6:0], sdat_s};

   always_comb begin
      rd_val = 8'h00;
      if ({1'b0, rd_addr} < NUM_REGS_B)
         rd_val = regs[rd_addr[IDX_W-1:0]];
   end

   always_ff @(posedge i_clock) begin
      if (i_reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sen_fall) state_nxt = SHIFT;
         SHIFT: begin
            if (sen_rise)
               state_nxt = IDLE;
            else if (sck_rise && bit_cnt == 4'd15)
               state_nxt = HOLD;
         end
         HOLD:    if (sen_rise) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A sen rise masks any sck edge seen in the same cycle.
   always_comb begin
      sck_take = 1'b0;
      load_rd  = 1'b0;
      commit   = 1'b0;
      abort    = 1'b0;
      tx_shift = 1'b0;
      if (state == SHIFT) begin
         if (sen_rise) begin
            abort = 1'b1;
         end else begin
            if (sck_rise) begin
               sck_take = 1'b1;
               load_rd  = (bit_cnt == 4'd7) && shreg[6];
               commit   = (bit_cnt == 4'd15) && !shreg[14] && ({1'b0, wr_addr} < NUM_REGS_B);
            end
            tx_shift = sck_fall && rd_active;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         bit_cnt      <= '0;
         shreg        <= '0;
         tx           <= '0;
         rd_active    <= 1'b0;
         o_sout       <= 1'b0;
         o_wrStrobe   <= 1'b0;
         o_wrAddress  <= '0;
         o_wrData     <= '0;
         o_rdStrobe   <= 1'b0;
         o_frameError <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= 8'h00;
      end else begin
         o_wrStrobe   <= commit;
         o_rdStrobe   <= load_rd;
         o_frameError <= abort;
         if (state == IDLE && sen_fall)
            bit_cnt <= '0;
         if (sck_take) begin
            shreg   <= {shreg[13:0], sdat_s};
            bit_cnt <= bit_cnt + 4'd1;
         end
         if (commit) begin
            regs[wr_addr[IDX_W-1:0]] <= wr_data;
            o_wrAddress              <= wr_addr;
            o_wrData                 <= wr_data;
         end
         // tx holds the bits still to be sent; o_sout carries the current one.
         if (state_nxt != SHIFT) begin
            rd_active <= 1'b0;
            tx        <= '0;
            o_sout    <= 1'b0;
         end else if (load_rd) begin
            rd_active <= 1'b1;
            tx        <= rd_val[6:0];
            o_sout    <= rd_val[7];
         end else if (tx_shift) begin
            tx     <= {tx[5:0], 1'b0};
            o_sout <= tx[6];
         end
      end
   end

endmodule

// File: tb/tb_spi_register_slave.sv
// Bench for spi_register_slave: two instances (32 and 16 registers) share one SPI master at i_clock/4.
// Stimulus pushes expected strobes/read bytes into queues; a monitor pops and compares.
module tb_spi_register_slave;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, sen, sck, sdat;
   logic [1:0] sout, wr_stb, rd_stb, f_err;
   logic [6:0] wr_adr [2];
   logic [7:0] wr_dat [2];

   spi_register_slave #(.NUM_REGS(32)) u_big (
      .i_clock(clk), .i_reset(rst), .i_sen(sen), .i_sck(sck), .i_sdat(sdat),
      .o_sout(sout[0]), .o_wrStrobe(wr_stb[0]), .o_wrAddress(wr_adr[0]),
      .o_wrData(wr_dat[0]), .o_rdStrobe(rd_stb[0]), .o_frameError(f_err[0])
   );

   spi_register_slave u_small (
      .i_clock(clk), .i_reset(rst), .i_sen(sen), .i_sck(sck), .i_sdat(sdat),
      .o_sout(sout[1]), .o_wrStrobe(wr_stb[1]), .o_wrAddress(wr_adr[1]),
      .o_wrData(wr_dat[1]), .o_rdStrobe(rd_stb[1]), .o_frameError(f_err[1])
   );

   // scoreboard queues, index 0 = 32-register instance, 1 = 16-register instance
   logic [14:0] exp_wr  [2][$];
   logic [7:0]  exp_rd  [2][$];
   bit          exp_err [2][$];
   logic        probe, done;
   logic [14:0] probe_exp [2];

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          cap_left [2];
   logic [7:0]  cap_val  [2];
   logic [7:0]  cap_exp  [2];

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // mode 0: sen rises with the last sck fall; mode 1: sen rises with the last sck rise
   task automatic frame(input logic [15:0] w, input int nbits, input int mode, input int rst_at);
      sen = 1'b0;
      sck = 1'b0;
      tick(2);
      for (int i = 0; i < nbits; i++) begin
         sdat = (i < 16) ? w[15-i] : 1'b0;
         tick(2);
         sck = 1'b1;
         if (mode == 1 && i == nbits - 1)
            sen = 1'b1;
         tick(2);
         sck = 1'b0;
         if (rst_at == i + 1) begin
            rst = 1'b1;
            tick(2);
            rst = 1'b0;
            do_probe(15'h0, 15'h0);
         end
      end
      sen = 1'b1;
      tick(6);
   endtask

   task automatic wr(input logic [6:0] a, input logic [7:0] d);
      frame({1'b0, a, d}, 16, 0, 0);
   endtask

   task automatic rd(input logic [6:0] a, input logic [7:0] e0, input logic [7:0] e1);
      exp_rd[0].push_back(e0);
      exp_rd[1].push_back(e1);
      frame({1'b1, a, 8'h00}, 16, 0, 0);
   endtask

   task automatic do_probe(input logic [14:0] e0, input logic [14:0] e1);
      probe_exp[0] = e0;
      probe_exp[1] = e1;
      probe = 1'b1;
      tick(1);
      probe = 1'b0;
   endtask

   task automatic push_wr(input int both, input logic [6:0] a, input logic [7:0] d);
      exp_wr[0].push_back({a, d});
      if (both != 0)
         exp_wr[1].push_back({a, d});
   endtask

   initial begin
      rst = 1'b1; sen = 1'b1; sck = 1'b0; sdat = 1'b0; probe = 1'b0; done = 1'b0;
      tick(4);
      rst = 1'b0;
      tick(4);
      do_probe(15'h0, 15'h0);

      push_wr(0, 7'h12, 8'h34);
      wr(7'h12, 8'h34);
      rd(7'h12, 8'h34, 8'h00);

      wr(7'h7F, 8'hAA);
      rd(7'h7F, 8'h00, 8'h00);
      do_probe({7'h12, 8'h34}, 15'h0);

      push_wr(1, 7'h0F, 8'h77);
      wr(7'h0F, 8'h77);
      push_wr(0, 7'h10, 8'h88);
      wr(7'h10, 8'h88);
      do_probe({7'h10, 8'h88}, {7'h0F, 8'h77});
      rd(7'h10, 8'h88, 8'h00);
      rd(7'h0F, 8'h77, 8'h77);

      exp_err[0].push_back(1'b1);
      exp_err[1].push_back(1'b1);
      frame({1'b0, 7'h03, 8'h99}, 10, 0, 0);
      rd(7'h03, 8'h00, 8'h00);
      push_wr(1, 7'h03, 8'h66);
      wr(7'h03, 8'h66);
      rd(7'h03, 8'h66, 8'h66);

      push_wr(1, 7'h05, 8'h5A);
      frame({1'b0, 7'h05, 8'h5A}, 20, 0, 0);
      rd(7'h05, 8'h5A, 8'h5A);

      exp_err[0].push_back(1'b1);
      exp_err[1].push_back(1'b1);
      frame({1'b0, 7'h06, 8'h11}, 16, 1, 0);
      rd(7'h06, 8'h00, 8'h00);

      frame({1'b0, 7'h07, 8'h22}, 16, 0, 12);
      rd(7'h05, 8'h00, 8'h00);
      rd(7'h07, 8'h00, 8'h00);
      push_wr(1, 7'h01, 8'hC3);
      wr(7'h01, 8'hC3);
      rd(7'h01, 8'hC3, 8'hC3);

      tick(10);
      done = 1'b1;
   end

   initial begin
      logic       sck_q;
      logic [14:0] e;
      sck_q = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cap_left[k] = 0;
         cap_val[k]  = 8'h00;
         cap_exp[k]  = 8'h00;
      end
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc > 20000) begin
            $display("FAIL watchdog cycles=%0d limit=20000", cyc);
            $fatal(1, "watchdog expired");
         end
         for (int k = 0; k < 2; k++) begin
            if (wr_stb[k]) begin
               tests++;
               if (exp_wr[k].size() == 0) begin
                  fails++;
                  $display("FAIL wr_strobe[%0d] got addr=%h data=%h required no strobe", k, wr_adr[k], wr_dat[k]);
               end else begin
                  e = exp_wr[k].pop_front();
                  if ({wr_adr[k], wr_dat[k]} !== e) begin
                     fails++;
                     $display("FAIL wr_commit[%0d] got addr=%h data=%h required addr=%h data=%h",
                              k, wr_adr[k], wr_dat[k], e[14:8], e[7:0]);
                  end
               end
            end
            if (f_err[k]) begin
               tests++;
               if (exp_err[k].size() == 0) begin
                  fails++;
                  $display("FAIL frame_error[%0d] got pulse required none", k);
               end else begin
                  void'(exp_err[k].pop_front());
               end
            end
            if (!sck_q && sck && cap_left[k] > 0) begin
               cap_val[k] = {cap_val[k][6:0], sout[k]};
               cap_left[k]--;
               if (cap_left[k] == 0) begin
                  tests++;
                  if (cap_val[k] !== cap_exp[k]) begin
                     fails++;
                     $display("FAIL read_data[%0d] got %h required %h", k, cap_val[k], cap_exp[k]);
                  end
               end
            end
            if (rd_stb[k]) begin
               tests++;
               if (exp_rd[k].size() == 0 || cap_left[k] != 0) begin
                  fails++;
                  $display("FAIL rd_strobe[%0d] got pulse required none (pending=%0d)", k, exp_rd[k].size());
               end else begin
                  cap_exp[k]  = exp_rd[k].pop_front();
                  cap_left[k] = 8;
                  cap_val[k]  = 8'h00;
               end
            end
            if (probe) begin
               tests++;
               if ({wr_adr[k], wr_dat[k]} !== probe_exp[k]) begin
                  fails++;
                  $display("FAIL wr_regs[%0d] got addr=%h data=%h required addr=%h data=%h",
                           k, wr_adr[k], wr_dat[k], probe_exp[k][14:8], probe_exp[k][7:0]);
               end
               tests++;
               if (sout[k] !== 1'b0) begin
                  fails++;
                  $display("FAIL idle_sout[%0d] got %b required 0", k, sout[k]);
               end
            end
         end
         sck_q = sck;
         if (done) begin
            for (int k = 0; k < 2; k++) begin
               tests++;
               if (exp_wr[k].size() != 0 || exp_rd[k].size() != 0 || exp_err[k].size() != 0 || cap_left[k] != 0) begin
                  fails++;
                  $display("FAIL drain[%0d] got wr=%0d rd=%0d err=%0d bits=%0d outstanding required 0",
                           k, exp_wr[k].size(), exp_rd[k].size(), exp_err[k].size(), cap_left[k]);
               end
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
         end
      end
   end

endmodule
